// File: rtl/mc_request_queue.sv
// mc_request_queue: consumer end of the parser-to-memory-controller request path.
// Buffers timestamped requests in a DEPTH-entry FIFO and releases the head once
// the free-running cycle counter reaches its timestamp. Entry rules (legal op,
// non-decreasing time, bounded requests per timestamp) are enforced on accept;
// offending requests are consumed, dropped and reported on sticky flags.
// Optional build macro MCQ_BYPASS_EN: an empty queue forwards an already-due
// legal request combinationally to the output in its accept cycle.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready of the same interface, and ready depends
// on registered state only (bypass only adds a combinational in->out path).
module mc_request_queue #(
    parameter int ADDR_WIDTH    = 36,
    parameter int MEMOP_WIDTH   = 2,
    parameter int TIME_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int MAX_PER_CYCLE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [TIME_WIDTH-1:0]       in_time,
    input  logic [MEMOP_WIDTH-1:0]      in_op,
    input  logic [ADDR_WIDTH-1:0]       in_addr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [TIME_WIDTH-1:0]       out_time,
    output logic [MEMOP_WIDTH-1:0]      out_op,
    output logic [ADDR_WIDTH-1:0]       out_addr,
    output logic [TIME_WIDTH-1:0]       cur_time,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        err_order,
    output logic                        err_rate,
    output logic                        err_op
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SAME_W = $clog2(MAX_PER_CYCLE + 1);

    logic [TIME_WIDTH-1:0]  mem_time [DEPTH];
    logic [MEMOP_WIDTH-1:0] mem_op   [DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_addr [DEPTH];

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [TIME_WIDTH-1:0] cur_time_q;
    logic [TIME_WIDTH-1:0] last_time;
    logic [SAME_W-1:0]     same_cnt;

    logic accept;
    logic bad_op;
    logic bad_order;
    logic bad_rate;
    logic legal;
    logic fifo_valid;
    logic fifo_deq;
    logic bypass_hit;
    logic bypass_take;
    logic enq;

    assign cur_time = cur_time_q;
    assign count    = count_q;

    // Entry handshake and rule checks; the first failing rule wins the flag.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        accept    = in_valid & in_ready;
        bad_op    = (in_op == MEMOP_WIDTH'(3));
        bad_order = (in_time < last_time);
        bad_rate  = (in_time == last_time) && (same_cnt == SAME_W'(MAX_PER_CYCLE));
        legal     = accept & ~bad_op & ~bad_order & ~bad_rate;
    end

    // Head release, optional bypass of an empty queue, and output selection.
    always_comb begin
        fifo_valid = (count_q != '0) && (mem_time[rd_ptr] <= cur_time_q);
        bypass_hit = 1'b0;
`ifdef MCQ_BYPASS_EN
        bypass_hit = (count_q == '0) && legal && (in_time <= cur_time_q);
`endif
        if (bypass_hit) begin
            out_valid = 1'b1;
            out_time  = in_time;
            out_op    = in_op;
            out_addr  = in_addr;
        end else if (count_q != '0) begin
            out_valid = fifo_valid;
            out_time  = mem_time[rd_ptr];
            out_op    = mem_op[rd_ptr];
            out_addr  = mem_addr[rd_ptr];
        end else begin
            out_valid = 1'b0;
            out_time  = '0;
            out_op    = '0;
            out_addr  = '0;
        end
        bypass_take = bypass_hit & out_ready;
        fifo_deq    = fifo_valid & out_ready;
        enq         = legal & ~bypass_take;
    end

    // Free-running cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_time_q <= '0;
        end else if (cur_time_q != '1) begin
            cur_time_q <= cur_time_q + 1'b1;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_time[wr_ptr] <= in_time;
            mem_op[wr_ptr]   <= in_op;
            mem_addr[wr_ptr] <= in_addr;
        end
    end

    // Pointers wrap naturally at DEPTH; count tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, fifo_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-timestamp bookkeeping for every legal request, bypassed or stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_time <= '0;
            same_cnt  <= '0;
        end else if (legal) begin
            if (in_time == last_time) begin
                same_cnt <= same_cnt + 1'b1;
            end else begin
                same_cnt  <= SAME_W'(1);
                last_time <= in_time;
            end
        end
    end

    // Sticky violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_op    <= 1'b0;
            err_order <= 1'b0;
            err_rate  <= 1'b0;
        end else if (accept) begin
            if (bad_op) begin
                err_op <= 1'b1;
            end else if (bad_order) begin
                err_order <= 1'b1;
            end else if (bad_rate) begin
                err_rate <= 1'b1;
            end
        end
    end

endmodule
